// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port IDs and read-latency bounds for the cache-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic PORT_P1 = 1'b0;
  localparam logic PORT_P2 = 1'b1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Wide enough to hold RD_LAT_MAX.
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the requester that did not win last time wins a tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_c_o,
  output logic       grant_id_c_o
);

  always_comb begin
    grant_valid_c_o = |req_i;
    grant_id_c_o    = PORT_P1;
    if (req_i == 2'b11) begin
      grant_id_c_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_id_c_o = PORT_P2;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges two processor request ports onto one cache port with round-robin
// arbitration and a per-port req/ack handshake.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_Addr,
  input  logic [DATA_W-1:0] p1_DataIn,
  input  logic              p1_WE,
  output logic [DATA_W-1:0] p1_DataOut,
  output logic              p1_ack,
  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p2_Addr,
  input  logic [DATA_W-1:0] p2_DataIn,
  input  logic              p2_WE,
  output logic [DATA_W-1:0] p2_DataOut,
  output logic              p2_ack,
  output logic              cache_en,
  output logic [ADDR_W-1:0] cache_Addr,
  output logic [DATA_W-1:0] cache_DataIn,
  output logic              cache_WE,
  input  logic [DATA_W-1:0] cache_DataOut,
  output logic              sel
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
    $error("mem_port_arbiter: RD_LAT must be within 1..4");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              cache_en_q, cache_en_d;
  logic              cache_we_q, cache_we_d;
  logic              ack1_q, ack1_d;
  logic              ack2_q, ack2_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic              grant_valid_c;
  logic              grant_id_c;

  rr_arb2 u_rr_arb2 (
    .req_i           ({p2_req, p1_req}),
    .last_grant_i    (last_grant_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_id_c_o    (grant_id_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= PORT_P1;
      last_grant_q <= PORT_P2;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cache_en_q   <= 1'b0;
      cache_we_q   <= 1'b0;
      ack1_q       <= 1'b0;
      ack2_q       <= 1'b0;
      dout1_q      <= '0;
      dout2_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cache_en_q   <= cache_en_d;
      cache_we_q   <= cache_we_d;
      ack1_q       <= ack1_d;
      ack2_q       <= ack2_d;
      dout1_q      <= dout1_d;
      dout2_q      <= dout2_d;
    end
  end

  // Next state; strobes and acks are derived from the next state so they leave a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    dout1_d      = dout1_q;
    dout2_d      = dout2_q;

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          owner_d = grant_id_c;
          addr_d  = (grant_id_c == PORT_P2) ? p2_Addr   : p1_Addr;
          wdata_d = (grant_id_c == PORT_P2) ? p2_DataIn : p1_DataIn;
          we_d    = (grant_id_c == PORT_P2) ? p2_WE     : p1_WE;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == PORT_P2) begin
            dout2_d = cache_DataOut;
          end else begin
            dout1_d = cache_DataOut;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cache_en_d = (state_d == ACCESS);
    cache_we_d = (state_d == ACCESS) && we_d;
    ack1_d     = (state_d == DONE) && (owner_d == PORT_P1);
    ack2_d     = (state_d == DONE) && (owner_d == PORT_P2);
  end

  assign cache_en     = cache_en_q;
  assign cache_WE     = cache_we_q;
  assign cache_Addr   = addr_q;
  assign cache_DataIn = wdata_q;
  assign p1_ack       = ack1_q;
  assign p2_ack       = ack2_q;
  assign p1_DataOut   = dout1_q;
  assign p2_DataOut   = dout2_q;
  assign sel          = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance A uses RD_LAT=1, instance B uses RD_LAT=3.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_p1_req, a_p2_req, b_p1_req, b_p2_req;
  logic [15:0] p1_Addr, p1_DataIn, p2_Addr, p2_DataIn;
  logic        p1_WE, p2_WE;

  logic [15:0] a_p1_DataOut, a_p2_DataOut, b_p1_DataOut, b_p2_DataOut;
  logic        a_p1_ack, a_p2_ack, b_p1_ack, b_p2_ack;
  logic        a_cache_en, a_cache_WE, a_sel, b_cache_en, b_cache_WE, b_sel;
  logic [15:0] a_cache_Addr, a_cache_DataIn, a_cache_DataOut;
  logic [15:0] b_cache_Addr, b_cache_DataIn, b_cache_DataOut;

  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [15:0] pre_data;
  logic [15:0] mem [256];
  logic        a_pv;
  logic [15:0] a_pd;
  logic [2:0]  b_pv;
  logic [15:0] b_pd0, b_pd1, b_pd2;

  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] exp_a1, exp_a2, exp_b1, exp_b2;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .p1_req(a_p1_req), .p1_Addr(p1_Addr), .p1_DataIn(p1_DataIn), .p1_WE(p1_WE),
    .p1_DataOut(a_p1_DataOut), .p1_ack(a_p1_ack),
    .p2_req(a_p2_req), .p2_Addr(p2_Addr), .p2_DataIn(p2_DataIn), .p2_WE(p2_WE),
    .p2_DataOut(a_p2_DataOut), .p2_ack(a_p2_ack),
    .cache_en(a_cache_en), .cache_Addr(a_cache_Addr), .cache_DataIn(a_cache_DataIn),
    .cache_WE(a_cache_WE), .cache_DataOut(a_cache_DataOut), .sel(a_sel)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .p1_req(b_p1_req), .p1_Addr(p1_Addr), .p1_DataIn(p1_DataIn), .p1_WE(p1_WE),
    .p1_DataOut(b_p1_DataOut), .p1_ack(b_p1_ack),
    .p2_req(b_p2_req), .p2_Addr(p2_Addr), .p2_DataIn(p2_DataIn), .p2_WE(p2_WE),
    .p2_DataOut(b_p2_DataOut), .p2_ack(b_p2_ack),
    .cache_en(b_cache_en), .cache_Addr(b_cache_Addr), .cache_DataIn(b_cache_DataIn),
    .cache_WE(b_cache_WE), .cache_DataOut(b_cache_DataOut), .sel(b_sel)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Cache model: read data is valid exactly RD_LAT cycles after cache_en, garbage otherwise.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (a_cache_en && a_cache_WE) mem[a_cache_Addr[7:0]] <= a_cache_DataIn;
    else if (b_cache_en && b_cache_WE) mem[b_cache_Addr[7:0]] <= b_cache_DataIn;
    a_pv  <= a_cache_en && !a_cache_WE;
    a_pd  <= mem[a_cache_Addr[7:0]];
    b_pv  <= {b_pv[1:0], b_cache_en && !b_cache_WE};
    b_pd0 <= mem[b_cache_Addr[7:0]];
    b_pd1 <= b_pd0;
    b_pd2 <= b_pd1;
  end
  assign a_cache_DataOut = a_pv    ? a_pd  : 16'hdead;
  assign b_cache_DataOut = b_pv[2] ? b_pd2 : 16'hdead;

  // Scoreboard: every ack pops one expected completion and checks both DataOut ports.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (a_p1_ack || a_p2_ack)) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL sb_a: unexpected ack p1_ack=%b p2_ack=%b, required no ack", a_p1_ack, a_p2_ack);
      end else begin
        e = qa.pop_front();
        if (a_p1_ack !== (e.port == 1'b0) || a_p2_ack !== (e.port == 1'b1) ||
            a_p1_DataOut !== e.d1 || a_p2_DataOut !== e.d2) begin
          bad++;
          $display("FAIL sb_a: got acks=%b%b d1=%h d2=%h, required port=%0d d1=%h d2=%h",
                   a_p2_ack, a_p1_ack, a_p1_DataOut, a_p2_DataOut, e.port, e.d1, e.d2);
        end
      end
    end
    if (!rst && (b_p1_ack || b_p2_ack)) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL sb_b: unexpected ack p1_ack=%b p2_ack=%b, required no ack", b_p1_ack, b_p2_ack);
      end else begin
        e = qb.pop_front();
        if (b_p1_ack !== (e.port == 1'b0) || b_p2_ack !== (e.port == 1'b1) ||
            b_p1_DataOut !== e.d1 || b_p2_DataOut !== e.d2) begin
          bad++;
          $display("FAIL sb_b: got acks=%b%b d1=%h d2=%h, required port=%0d d1=%h d2=%h",
                   b_p2_ack, b_p1_ack, b_p1_DataOut, b_p2_DataOut, e.port, e.d1, e.d2);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_p1_req = 1'b0; a_p2_req = 1'b0; b_p1_req = 1'b0; b_p2_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete(); qb.delete();
    exp_a1 = '0; exp_a2 = '0; exp_b1 = '0; exp_b2 = '0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [15:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Waits (bounded) for the selected ack; returns its cycle number or -1.
  task automatic wait_ack(input bit on_b, input bit port, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((on_b ? (port ? b_p2_ack : b_p1_ack) : (port ? a_p2_ack : a_p1_ack)) === 1'b1) begin
        at_cyc = cyc_n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int t0, at;
    logic [68:0] v;
    v = {a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn, a_p1_ack, a_p2_ack,
         a_p1_DataOut, a_p2_DataOut, a_sel};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_state: got %h, required 0", v); end
    preload(8'h20, 16'haaaa);
    @(negedge clk);
    a_p1_req = 1'b1; p1_Addr = 16'h0020; p1_DataIn = 16'h0; p1_WE = 1'b0;
    @(negedge clk);
    total++;
    if (a_cache_en !== 1'b1) begin bad++; $display("FAIL rst_pre_en: got %b, required 1", a_cache_en); end
    @(negedge clk);
    rst = 1'b1; a_p1_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v = {a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn, a_p1_ack, a_p2_ack,
           a_p1_DataOut, a_p2_DataOut, a_sel};
      total++;
      if (v !== '0) begin bad++; $display("FAIL rst_mid_read: got %h, required 0", v); end
    end
    rst = 1'b0;
    qa.push_back('{port: 1'b0, d1: 16'haaaa, d2: 16'h0});
    exp_a1 = 16'haaaa;
    a_p1_req = 1'b1; t0 = cyc_n;
    wait_ack(1'b0, 1'b0, at);
    a_p1_req = 1'b0;
    total++;
    if (at < 0 || at - t0 != 3) begin bad++; $display("FAIL rst_recover_lat: got %0d, required 3", at - t0); end
  endtask

  task automatic test_write();
    do_reset();
    qa.push_back('{port: 1'b0, d1: exp_a1, d2: exp_a2});
    @(negedge clk);
    a_p1_req = 1'b1; p1_Addr = 16'h0010; p1_DataIn = 16'hf0f0; p1_WE = 1'b1;
    @(negedge clk);
    total++;
    if ({a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn, a_sel} !== {2'b11, 16'h0010, 16'hf0f0, 1'b0}) begin
      bad++;
      $display("FAIL wr_cycle1: got en=%b we=%b a=%h d=%h sel=%b, required 1 1 0010 f0f0 0",
               a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn, a_sel);
    end
    @(negedge clk);
    total++;
    if (a_p1_ack !== 1'b1 || a_p1_DataOut !== 16'h0) begin
      bad++; $display("FAIL wr_cycle2: got ack=%b dout=%h, required 1 0000", a_p1_ack, a_p1_DataOut);
    end
    a_p1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_p1_ack, a_cache_en, a_cache_WE, a_cache_Addr} !== {3'b000, 16'h0010}) begin
      bad++;
      $display("FAIL wr_after: got ack=%b en=%b we=%b a=%h, required 0 0 0 0010",
               a_p1_ack, a_cache_en, a_cache_WE, a_cache_Addr);
    end
  endtask

  task automatic test_read();
    int t0, at;
    do_reset();
    preload(8'hff, 16'h1234);
    qa.push_back('{port: 1'b1, d1: exp_a1, d2: 16'h1234});
    exp_a2 = 16'h1234;
    @(negedge clk);
    a_p2_req = 1'b1; p2_Addr = 16'hffff; p2_DataIn = 16'h0; p2_WE = 1'b0; t0 = cyc_n;
    @(negedge clk);
    total++;
    if ({a_cache_en, a_cache_WE, a_sel, a_cache_Addr} !== {3'b101, 16'hffff}) begin
      bad++;
      $display("FAIL rd_cycle1: got en=%b we=%b sel=%b a=%h, required 1 0 1 ffff",
               a_cache_en, a_cache_WE, a_sel, a_cache_Addr);
    end
    wait_ack(1'b0, 1'b1, at);
    a_p2_req = 1'b0;
    total++;
    if (at < 0 || at - t0 != 3 || a_p2_DataOut !== 16'h1234 || a_p1_DataOut !== 16'h0) begin
      bad++;
      $display("FAIL rd_ack: got lat=%0d d2=%h d1=%h, required 3 1234 0000", at - t0, a_p2_DataOut, a_p1_DataOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_addr [4];
    int k_en, n1, n2;
    k_en = 0; n1 = 0; n2 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_addr[k] = k[0] ? 16'h0200 + 16'(k / 2) : 16'h0100 + 16'(k / 2);
      qa.push_back('{port: k[0], d1: 16'h0, d2: 16'h0});
    end
    @(negedge clk);
    a_p1_req = 1'b1; p1_Addr = 16'h0100; p1_DataIn = 16'h1100; p1_WE = 1'b1;
    a_p2_req = 1'b1; p2_Addr = 16'h0200; p2_DataIn = 16'h2200; p2_WE = 1'b1;
    for (int i = 0; i < 40 && !(n1 == 2 && n2 == 2); i++) begin
      @(negedge clk);
      if (a_cache_en === 1'b1) begin
        total++;
        if (k_en >= 4) begin
          bad++; $display("FAIL rr_extra: got access %0d, required 4 accesses", k_en);
        end else if ({a_sel, a_cache_Addr} !== {k_en[0], exp_addr[k_en]}) begin
          bad++;
          $display("FAIL rr_order: access %0d got sel=%b a=%h, required %b %h",
                   k_en, a_sel, a_cache_Addr, k_en[0], exp_addr[k_en]);
        end
        k_en++;
      end
      if (a_p1_ack === 1'b1) begin
        n1++;
        if (n1 < 2) begin p1_Addr = 16'h0101; p1_DataIn = 16'h1101; end
        else a_p1_req = 1'b0;
      end
      if (a_p2_ack === 1'b1) begin
        n2++;
        if (n2 < 2) begin p2_Addr = 16'h0201; p2_DataIn = 16'h2201; end
        else a_p2_req = 1'b0;
      end
    end
    a_p1_req = 1'b0; a_p2_req = 1'b0;
    total++;
    if (n1 != 2 || n2 != 2 || k_en != 4) begin
      bad++; $display("FAIL rr_counts: got n1=%0d n2=%0d acc=%0d, required 2 2 4", n1, n2, k_en);
    end
  endtask

  task automatic test_rd_lat3();
    int t0, at;
    do_reset();
    preload(8'h40, 16'h00ff);
    qb.push_back('{port: 1'b0, d1: 16'h00ff, d2: exp_b2});
    exp_b1 = 16'h00ff;
    @(negedge clk);
    b_p1_req = 1'b1; p1_Addr = 16'h0040; p1_DataIn = 16'h0; p1_WE = 1'b0; t0 = cyc_n;
    @(negedge clk);
    total++;
    if (b_cache_en !== 1'b1) begin bad++; $display("FAIL lat3_en: got %b, required 1", b_cache_en); end
    @(negedge clk);
    b_p1_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (b_p1_ack !== 1'b0 || b_p1_DataOut !== 16'h0) begin
        bad++; $display("FAIL lat3_early: cycle %0d got ack=%b d=%h, required 0 0000", c, b_p1_ack, b_p1_DataOut);
      end
      if (c < 4) @(negedge clk);
    end
    wait_ack(1'b1, 1'b0, at);
    total++;
    if (at < 0 || at - t0 != 5 || b_p1_DataOut !== 16'h00ff) begin
      bad++; $display("FAIL lat3_ack: got lat=%0d d=%h, required 5 00ff", at - t0, b_p1_DataOut);
    end
  endtask

  task automatic test_latch();
    int t0, at;
    do_reset();
    qa.push_back('{port: 1'b0, d1: exp_a1, d2: exp_a2});
    @(negedge clk);
    a_p1_req = 1'b1; p1_Addr = 16'h0033; p1_DataIn = 16'h5a5a; p1_WE = 1'b1; t0 = cyc_n;
    @(posedge clk);
    #1;
    p1_Addr = 16'h0000; p1_DataIn = 16'h0000;
    @(negedge clk);
    total++;
    if ({a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn} !== {2'b11, 16'h0033, 16'h5a5a}) begin
      bad++;
      $display("FAIL latch_wr: got en=%b we=%b a=%h d=%h, required 1 1 0033 5a5a",
               a_cache_en, a_cache_WE, a_cache_Addr, a_cache_DataIn);
    end
    wait_ack(1'b0, 1'b0, at);
    a_p1_req = 1'b0;
    total++;
    if (at < 0 || at - t0 != 2) begin bad++; $display("FAIL latch_lat: got %0d, required 2", at - t0); end
    qa.push_back('{port: 1'b1, d1: exp_a1, d2: 16'h5a5a});
    exp_a2 = 16'h5a5a;
    @(negedge clk);
    a_p2_req = 1'b1; p2_Addr = 16'h0033; p2_WE = 1'b0; t0 = cyc_n;
    wait_ack(1'b0, 1'b1, at);
    a_p2_req = 1'b0;
    total++;
    if (at < 0 || at - t0 != 3 || a_p2_DataOut !== 16'h5a5a) begin
      bad++; $display("FAIL latch_rdback: got lat=%0d d=%h, required 3 5a5a", at - t0, a_p2_DataOut);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_p1_req = 1'b0; a_p2_req = 1'b0; b_p1_req = 1'b0; b_p2_req = 1'b0;
    p1_Addr = '0; p1_DataIn = '0; p1_WE = 1'b0;
    p2_Addr = '0; p2_DataIn = '0; p2_WE = 1'b0;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    exp_a1 = '0; exp_a2 = '0; exp_b1 = '0; exp_b2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_rd_lat3();
    test_latch();
    repeat (4) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++; $display("FAIL sb_drain: got pending a=%0d b=%0d, required 0 0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
